ext_bus_master: RTL and testbench
=================================

Name: ext_bus_master

Overview:
- Wishbone-slave to byte-wide off-chip bus bridge. It sits directly upstream of the top-level pad mapping and drives oib_clk, ob_data and ob_pty. It consumes ib_data and ib_pty.
- Microwatt's external-bus wishbone port issues single 32-bit accesses.
- Each access is serialised into a parity-protected request frame. The block then waits for a response frame and returns ack/err plus read data to the core.

Parameters:
- TIMEOUT_TICKS, 1024, byte ticks allowed in WAIT_RSP before the transaction is aborted with err.
- ADR_W, 30, wishbone word-address width; only the low 30 bits are transmitted.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- wb_cyc  in  1  wishbone cycle
- wb_stb  in  1  wishbone strobe
- wb_we  in  1  write enable
- wb_sel  in  4  byte selects
- wb_adr  in  ADR_W  word address
- wb_dat_w  in  32  write data
- wb_dat_r  out  32  read data, valid with wb_ack
- wb_ack  out  1  one-cycle acknowledge
- wb_err  out  1  one-cycle error (timeout, parity, remote error)
- wb_stall  out  1  pipelined stall
- oib_clk  out  1  bus clock, clk/2
- ob_data  out  8  outbound byte
- ob_pty  out  1  outbound odd parity
- ib_data  in  8  inbound byte
- ib_pty  in  1  inbound odd parity

Behaviour:
- **Reset values:** ob_data=0x00, ob_pty=1, oib_clk=0, wb_ack=0, wb_err=0, wb_dat_r=0, wb_stall=0, state=IDLE, phase=0.
- **Byte tick:**
  - phase toggles every clk; oib_clk=phase (registered).
  - The tick is the cycle where phase goes 1->0. On that edge ob_data/ob_pty update, so they are stable for the whole oib_clk-high period.
  - ib_data/ib_pty are sampled on the same tick.
  - One byte moves per 2 clk.
- **Parity:** odd; pty = ~^data. The idle byte is 0x00 with pty=1. An inbound parity mismatch on any byte while in WAIT_RSP/RDATA gives wb_err.
- **Request frame**, LSB byte first:
  - Header: {1'b1, we, 2'b00, sel[3:0]}.
  - Address: 4 bytes of {2'b00, adr}.
  - Write data: 4 bytes, sent only if we=1.
  - Write frame = 9 bytes; read frame = 5 bytes. The idle byte is driven between frames.
- **Response frame:**
  - Bytes with bit7=0 are idle and ignored.
  - 0x80 = OK; 0x81 = remote error; any other byte with bit7=1 = error.
  - A read OK is followed by 4 data bytes, LSB first, on consecutive ticks.
- **State machine:**
  - IDLE: wb_stall=0. When cyc&stb, latch we/sel/adr/dat, set wb_stall=1 and go to HDR.
  - HDR -> ADDR(idx 0..3) -> WDATA(0..3) if we, else straight to WAIT_RSP. Each of these advances one state per tick.
  - WAIT_RSP: increment the timeout counter each tick.
    - OK+write -> DONE_ACK.
    - OK+read -> RDATA(0..3).
    - Error byte, parity error, or counter==TIMEOUT_TICKS-1 -> DONE_ERR.
  - RDATA: shift bytes into wb_dat_r[8*idx+:8]. A parity error -> DONE_ERR.
  - DONE_ACK / DONE_ERR: pulse wb_ack or wb_err for exactly 1 clk, then return to IDLE the next cycle.
  - wb_stall=1 in every state except IDLE.
- **Latency:** write OK with the response arriving on the first WAIT_RSP tick: ack 21 clk after the accepting cycle (±1 for phase alignment).
- **Cycle abort:** if wb_cyc drops mid-transaction, the outbound frame still completes and the response is consumed. Ack/err is suppressed and the FSM returns to IDLE.
- **Reset mid-frame:** immediate return to the reset values. Any partial frame is truncated and the idle byte is driven next tick.
- **Mutual exclusion:** wb_ack and wb_err are never high together. There is never more than one outstanding access.
- **Response timing:** inbound response bytes arriving before WAIT_RSP are ignored.

Decomposition:
- Package ext_bus_pkg:
  - HDR_START bit index.
  - RSP_OK=8'h80, RSP_ERR=8'h81, IDLE_BYTE=8'h00.
  - FSM state enum.
  - Odd-parity function.
- Sub-module ext_bus_phy:
  - Phase/oib_clk generator and tick strobe.
  - Outbound byte/parity register.
  - Inbound sample register with parity-error flag.
- The FSM stays in ext_bus_master.

Test Plan:
- **Write:** adr=0x0000_1234, dat=0xDEADBEEF, sel=0xF, we=1. Required ob bytes: 0xCF, 0x34, 0x12, 0x00, 0x00, 0xEF, 0xBE, 0xAD, 0xDE with correct odd parity; response 0x80 -> one wb_ack, wb_err=0.
- **Read:** adr=0x10, sel=0x3. Required header byte 0x83, then 4 address bytes; response 0x80, 0x78, 0x56, 0x34, 0x12 -> wb_ack with wb_dat_r=0x12345678.
- **Timeout:** read with ib held at 0x00/pty=1 -> wb_err exactly TIMEOUT_TICKS ticks after entering WAIT_RSP, no ack; next access accepted normally.
- **Parity/remote error:** response 0x80 with ib_pty wrong -> wb_err. Separately, response 0x81 -> wb_err. wb_dat_r must not be reported with an ack in either case.
- **Reset mid-frame:** assert rst after the 3rd address byte -> next tick ob_data=0x00, ob_pty=1, wb_stall=0, no ack/err.
- **Cycle abort:** drop wb_cyc during WDATA -> frame completes (9 bytes), response consumed, no ack/err pulse, FSM back in IDLE.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg: shared constants, FSM states and parity helper for the external bus bridge
package ext_bus_pkg;
    localparam int         HDR_START = 7;
    localparam logic [7:0] RSP_OK    = 8'h80;
    localparam logic [7:0] RSP_ERR   = 8'h81;
    localparam logic [7:0] IDLE_BYTE = 8'h00;
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ADDR, S_WDATA, S_WAIT_RSP, S_RDATA, S_DONE_ACK, S_DONE_ERR
    } state_t;
    function automatic logic odd_pty(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ext_bus_master_if.sv
// ext_bus_master_if: wishbone slave port plus byte-wide off-chip bus lanes
interface ext_bus_master_if #(
    parameter int ADR_W = 30
);
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [3:0]       wb_sel;
    logic [ADR_W-1:0] wb_adr;
    logic [31:0]      wb_dat_w;
    logic [31:0]      wb_dat_r;
    logic             wb_ack;
    logic             wb_err;
    logic             wb_stall;
    logic             oib_clk;
    logic [7:0]       ob_data;
    logic             ob_pty;
    logic [7:0]       ib_data;
    logic             ib_pty;
    modport master (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w, ib_data, ib_pty,
        output wb_dat_r, wb_ack, wb_err, wb_stall, oib_clk, ob_data, ob_pty
    );
    modport slave (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w, ib_data, ib_pty,
        input  wb_dat_r, wb_ack, wb_err, wb_stall, oib_clk, ob_data, ob_pty
    );
endinterface

// File: rtl/ext_bus_phy.sv
// ext_bus_phy: byte-tick generator and registered outbound/inbound byte lanes
module ext_bus_phy
    import ext_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte_i,
    input  logic       rx_en_i,
    input  logic [7:0] ib_data_i,
    input  logic       ib_pty_i,
    output logic       tick_o,
    output logic       oib_clk_o,
    output logic [7:0] ob_data_o,
    output logic       ob_pty_o,
    output logic       rx_vld_o,
    output logic [7:0] rx_data_o,
    output logic       rx_perr_o
);
    logic       phase_q, ob_pty_q, rx_vld_q, rx_perr_q;
    logic [7:0] ob_data_q, rx_data_q;
    assign tick_o    = phase_q;
    assign oib_clk_o = phase_q;
    assign ob_data_o = ob_data_q;
    assign ob_pty_o  = ob_pty_q;
    assign rx_vld_o  = rx_vld_q;
    assign rx_data_o = rx_data_q;
    assign rx_perr_o = rx_perr_q;
    // Phase falls on the tick: outbound byte launches and inbound byte is sampled together.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= 1'b0;
            ob_data_q <= IDLE_BYTE;
            ob_pty_q  <= odd_pty(IDLE_BYTE);
            rx_data_q <= IDLE_BYTE;
            rx_perr_q <= 1'b0;
            rx_vld_q  <= 1'b0;
        end else begin
            phase_q  <= ~phase_q;
            rx_vld_q <= phase_q & rx_en_i;
            if (phase_q) begin
                ob_data_q <= tx_byte_i;
                ob_pty_q  <= odd_pty(tx_byte_i);
                rx_data_q <= ib_data_i;
                rx_perr_q <= ib_pty_i != odd_pty(ib_data_i);
            end
        end
    end
endmodule

// File: rtl/ext_bus_master.sv
// ext_bus_master: wishbone slave to parity-protected byte-wide off-chip bus bridge
module ext_bus_master
    import ext_bus_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 1024,
    parameter int ADR_W         = 30
) (
    input logic              clk,
    input logic              rst,
    ext_bus_master_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_TICKS);
    state_t           state_q, state_d, ack_st, err_st;
    logic [1:0]       idx_q, idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             abort_q, abort_d;
    logic [31:0]      rdat_q, rdat_d;
    logic             we_q;
    logic [3:0]       sel_q;
    logic [ADR_W-1:0] adr_q;
    logic [31:0]      wdat_q, adr_word;
    logic             accept, abort, tick, rx_vld, rx_perr;
    logic [7:0]       tx_byte, rx_data;
    assign accept   = (state_q == S_IDLE) && bus.wb_cyc && bus.wb_stb;
    assign abort    = abort_q | ~bus.wb_cyc;
    assign ack_st   = abort ? S_IDLE : S_DONE_ACK;
    assign err_st   = abort ? S_IDLE : S_DONE_ERR;
    assign adr_word = {2'b00, adr_q[29:0]};
    assign tx_byte  = (state_q == S_HDR)   ? {1'b1, we_q, 2'b00, sel_q} :
                      (state_q == S_ADDR)  ? adr_word[8*idx_q +: 8] :
                      (state_q == S_WDATA) ? wdat_q[8*idx_q +: 8] : IDLE_BYTE;
    assign bus.wb_ack   = state_q == S_DONE_ACK;
    assign bus.wb_err   = state_q == S_DONE_ERR;
    assign bus.wb_stall = state_q != S_IDLE;
    assign bus.wb_dat_r = rdat_q;
    ext_bus_phy u_phy (
        .clk       (clk),
        .rst       (rst),
        .tx_byte_i (tx_byte),
        .rx_en_i   ((state_q == S_WAIT_RSP) || (state_q == S_RDATA)),
        .ib_data_i (bus.ib_data),
        .ib_pty_i  (bus.ib_pty),
        .tick_o    (tick),
        .oib_clk_o (bus.oib_clk),
        .ob_data_o (bus.ob_data),
        .ob_pty_o  (bus.ob_pty),
        .rx_vld_o  (rx_vld),
        .rx_data_o (rx_data),
        .rx_perr_o (rx_perr)
    );
    // Frame sequencing, response decode and timeout; a dropped cycle only suppresses the final pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = (state_q == S_WAIT_RSP) ? tmo_q : '0;
        abort_d = (state_q == S_IDLE) ? 1'b0 : abort;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: state_d = accept ? S_HDR : S_IDLE;
            S_HDR: begin
                if (tick) begin
                    state_d = S_ADDR;
                    idx_d   = '0;
                end
            end
            S_ADDR: begin
                if (tick) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = we_q ? S_WDATA : S_WAIT_RSP;
                end
            end
            S_WDATA: begin
                if (tick) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rx_vld) begin
                    tmo_d = tmo_q + TW'(1);
                    idx_d = '0;
                    if (rx_perr) state_d = err_st;
                    else if (rx_data[HDR_START]) state_d = (rx_data != RSP_OK) ? err_st : we_q ? ack_st : S_RDATA;
                    else if (tmo_q == TW'(TIMEOUT_TICKS - 1)) state_d = err_st;
                end
            end
            S_RDATA: begin
                if (rx_vld) begin
                    idx_d = idx_q + 2'd1;
                    if (rx_perr) state_d = err_st;
                    else begin
                        rdat_d[8*idx_q +: 8] = rx_data;
                        if (idx_q == 2'd3) state_d = ack_st;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    // FSM and read-data state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
            rdat_q  <= rdat_d;
        end
    end
    // Request fields are captured once, when the access is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            wdat_q <= '0;
        end else if (accept) begin
            we_q   <= bus.wb_we;
            sel_q  <= bus.wb_sel;
            adr_q  <= bus.wb_adr;
            wdat_q <= bus.wb_dat_w;
        end
    end
endmodule

// File: tb/tb_ext_bus_master.sv
// tb_ext_bus_master: directed checks of frames, responses, timeout, reset and abort
module tb_ext_bus_master;
    import ext_bus_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fr [9];
    int          n_ack, n_err, k_done, h;
    int          n_both = 0;
    logic [31:0] dat_ack;
    logic        pty_bad, mid_stall, end_stall, r_pty, r_stall, r_oib, r_ae;
    logic [7:0]  end_ob, r_ob;
    ext_bus_master_if #(.ADR_W(30)) bus ();
    ext_bus_master #(.TIMEOUT_TICKS(1024), .ADR_W(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    // 10 ns core clock.
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic check_frame(input string tag, input logic [71:0] exp, input int n);
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), {24'h0, fr[i]}, {24'h0, exp[8*i +: 8]});
    endtask
    task automatic set_ib(input logic [7:0] b, input logic bad);
        bus.ib_data = b;
        bus.ib_pty  = ~^b ^ bad;
    endtask
    task automatic xfer(input logic we, input logic [3:0] sel, input logic [29:0] adr, input logic [31:0] dat,
                        input logic [39:0] rsp, input int rsp_n, input logic [4:0] bad, input logic early,
                        input int drop_rel, input int rst_rel, input int budget);
        int nb, wt;
        nb = we ? 9 : 5;
        n_ack = 0; n_err = 0; k_done = -1; dat_ack = '0; pty_bad = 1'b0; mid_stall = 1'b0;
        r_ob = 'x; r_pty = 'x; r_stall = 'x; r_oib = 'x; r_ae = 'x;
        for (int i = 0; i < 9; i++) fr[i] = 'x;
        @(negedge clk);
        h  = bus.oib_clk ? 2 : 1;
        wt = h + (we ? 18 : 10);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
        bus.wb_sel = sel; bus.wb_adr = adr; bus.wb_dat_w = dat;
        set_ib(early ? rsp[7:0] : IDLE_BYTE, 1'b0);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (k == 0) bus.wb_stb = 1'b0;
            if (rst_rel >= 0 && k == h + rst_rel + 1) begin
                r_ob = bus.ob_data; r_pty = bus.ob_pty; r_stall = bus.wb_stall;
                r_oib = bus.oib_clk; r_ae = bus.wb_ack | bus.wb_err;
                rst = 1'b0;
            end
            if (k >= h && ((k - h) % 2) == 0 && (k - h) / 2 < nb && (rst_rel < 0 || k <= h + rst_rel)) begin
                fr[(k - h) / 2] = bus.ob_data;
                if (bus.ob_pty !== ~^bus.ob_data) pty_bad = 1'b1;
            end
            if (bus.wb_ack && bus.wb_err) n_both++;
            if (bus.wb_ack) begin
                n_ack++;
                if (k_done < 0) begin k_done = k; dat_ack = bus.wb_dat_r; end
            end
            if (bus.wb_err) begin
                n_err++;
                if (k_done < 0) k_done = k;
            end
            if (bus.wb_ack || bus.wb_err) bus.wb_cyc = 1'b0;
            if (k == h + 17) mid_stall = bus.wb_stall;
            if (drop_rel >= 0 && k == h + drop_rel) bus.wb_cyc = 1'b0;
            if (rst_rel >= 0 && k == h + rst_rel) begin
                rst = 1'b1; bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
            end
            for (int j = 0; j < rsp_n; j++) if (k + 1 == wt + 2 * j) set_ib(rsp[8*j +: 8], bad[j]);
            if (rsp_n > 0 && k + 1 == wt + 2 * rsp_n) set_ib(IDLE_BYTE, 1'b0);
            if (k_done >= 0 && k >= k_done + 4) break;
        end
        end_stall = bus.wb_stall;
        end_ob    = bus.ob_data;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
        set_ib(IDLE_BYTE, 1'b0);
    endtask
    // Directed sequence: reset, write, read, error responses, timeout, reset mid-frame, cycle abort.
    initial begin
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0; bus.wb_sel = '0;
        bus.wb_adr = '0; bus.wb_dat_w = '0;
        set_ib(IDLE_BYTE, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_ob_data", {24'h0, bus.ob_data}, 32'h0);
        check("rst_ob_pty", {31'h0, bus.ob_pty}, 32'h1);
        check("rst_oib_clk", {31'h0, bus.oib_clk}, 32'h0);
        check("rst_ack", {31'h0, bus.wb_ack}, 32'h0);
        check("rst_err", {31'h0, bus.wb_err}, 32'h0);
        check("rst_dat_r", bus.wb_dat_r, 32'h0);
        check("rst_stall", {31'h0, bus.wb_stall}, 32'h0);
        rst = 1'b0;
        xfer(1'b1, 4'hF, 30'h1234, 32'hDEADBEEF, {32'h0, RSP_OK}, 1, 5'b0, 1'b1, -1, -1, 60);
        check_frame("wr", 72'hDE_AD_BE_EF_00_00_12_34_CF, 9);
        check("wr_pty", {31'h0, pty_bad}, 32'h0);
        check("wr_ack", n_ack, 1);
        check("wr_err", n_err, 0);
        check("wr_latency", k_done, h + 19);
        xfer(1'b0, 4'h3, 30'h10, 32'h0, 40'h12_34_56_78_80, 5, 5'b0, 1'b0, -1, -1, 60);
        check_frame("rd", 72'h00_00_00_00_10_83, 5);
        check("rd_pty", {31'h0, pty_bad}, 32'h0);
        check("rd_ack", n_ack, 1);
        check("rd_err", n_err, 0);
        check("rd_data", dat_ack, 32'h12345678);
        check("rd_latency", k_done, h + 19);
        xfer(1'b0, 4'h3, 30'h10, 32'h0, {32'h0, RSP_OK}, 1, 5'b00001, 1'b0, -1, -1, 60);
        check("perr_err", n_err, 1);
        check("perr_ack", n_ack, 0);
        check("perr_latency", k_done, h + 11);
        xfer(1'b0, 4'h3, 30'h10, 32'h0, {32'h0, RSP_ERR}, 1, 5'b0, 1'b0, -1, -1, 60);
        check("remote_err", n_err, 1);
        check("remote_ack", n_ack, 0);
        check("remote_latency", k_done, h + 11);
        xfer(1'b0, 4'hF, 30'h20, 32'h0, 40'h0, 0, 5'b0, 1'b0, -1, -1, 2200);
        check("tmo_err", n_err, 1);
        check("tmo_ack", n_ack, 0);
        check("tmo_latency", k_done, h + 2057);
        xfer(1'b0, 4'h3, 30'h10, 32'h0, 40'hA1_B2_C3_D4_80, 5, 5'b0, 1'b0, -1, -1, 60);
        check("post_tmo_ack", n_ack, 1);
        check("post_tmo_data", dat_ack, 32'hA1B2C3D4);
        xfer(1'b1, 4'h5, 30'h1122_3344, 32'h0, 40'h0, 0, 5'b0, 1'b0, -1, 6, 40);
        check_frame("rstmid", 72'h22_33_44_C5, 4);
        check("rstmid_ob_data", {24'h0, r_ob}, 32'h0);
        check("rstmid_ob_pty", {31'h0, r_pty}, 32'h1);
        check("rstmid_stall", {31'h0, r_stall}, 32'h0);
        check("rstmid_oib_clk", {31'h0, r_oib}, 32'h0);
        check("rstmid_ack_err", {31'h0, r_ae}, 32'h0);
        check("rstmid_pulses", n_ack + n_err, 0);
        check("rstmid_idle_byte", {24'h0, end_ob}, 32'h0);
        xfer(1'b0, 4'h3, 30'h10, 32'h0, 40'h01_02_03_04_80, 5, 5'b0, 1'b0, -1, -1, 60);
        check("post_rst_ack", n_ack, 1);
        check("post_rst_data", dat_ack, 32'h01020304);
        xfer(1'b1, 4'hF, 30'h1234, 32'hDEADBEEF, {32'h0, RSP_OK}, 1, 5'b0, 1'b1, 12, -1, 40);
        check_frame("abort", 72'hDE_AD_BE_EF_00_00_12_34_CF, 9);
        check("abort_pulses", n_ack + n_err, 0);
        check("abort_mid_stall", {31'h0, mid_stall}, 32'h1);
        check("abort_end_stall", {31'h0, end_stall}, 32'h0);
        xfer(1'b0, 4'h3, 30'h10, 32'h0, 40'hCA_FE_BA_BE_80, 5, 5'b0, 1'b0, -1, -1, 60);
        check("post_abort_ack", n_ack, 1);
        check("post_abort_data", dat_ack, 32'hCAFEBABE);
        check("ack_err_overlap", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
